mem_req_ctrl: RTL

- Request front-end that sits directly upstream of the memory block and drives its access port.
- Accepts read/write requests on a valid/ready channel and buffers them in a small FIFO.
- Issues buffered requests to the memory one at a time, with the memory's fixed read latency.
- Returns one response per request (read data or write ack, plus an error flag) on a valid/ready response channel.

---
 rtl/mem_ctrl_pkg.sv | 12 +
 rtl/mem_req_fifo.sv | 48 ++++
 rtl/mem_req_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared request record, FSM state and counter width for mem_req_ctrl
package mem_ctrl_pkg;
  localparam int ERR_CNT_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous FIFO of request records with full/empty/occupancy
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter type T = mem_req_t,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  T            din,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  T mem_q [DEPTH];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: buffers read/write requests and issues them to memory one at a time,
// returning one in-order response per request
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT = 1,
  parameter int MAX_ADDR = 2**ADDR_W-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_wr,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);
  // request record at this instance's widths
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  req_t req_in, head;
  logic full, empty, pop;
  logic [CW-1:0] count;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rsp_data_q, rsp_data_d;
  logic rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d, rsp_err_q, rsp_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  assign req_in = {req_wr, req_addr, req_wdata};
  mem_req_fifo #(.T(req_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(req_valid && req_ready),
    .pop(pop),
    .din(req_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign req_ready = !full;
  assign busy = state_q != IDLE || count != '0;
  assign mem_en = mem_en_q;
  assign mem_wr = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr = rsp_wr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign err_count = err_cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pop = 1'b0;
    mem_en_d = 1'b0;
    mem_wr_d = 1'b0;
    mem_addr_d = '0;
    mem_wdata_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d = rsp_wr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        rsp_wr_d = head.wr;
        rsp_data_d = '0;
        rsp_err_d = int'(head.addr) > MAX_ADDR;
        state_d = rsp_err_d ? RESP : ISSUE;
        rsp_valid_d = rsp_err_d;
        mem_en_d = !rsp_err_d;
        mem_wr_d = !rsp_err_d && head.wr;
        mem_addr_d = rsp_err_d ? '0 : head.addr;
        mem_wdata_d = rsp_err_d ? '0 : head.wdata;
      end
      ISSUE: begin
        state_d = mem_wr_q ? RESP : WAIT_RD;
        rsp_valid_d = mem_wr_q;
        cnt_d = 2'(RD_LAT - 1);
      end
      WAIT_RD: begin
        state_d = cnt_q == 2'd0 ? RESP : WAIT_RD;
        rsp_valid_d = cnt_q == 2'd0;
        rsp_data_d = cnt_q == 2'd0 ? mem_rdata : rsp_data_q;
        cnt_d = cnt_q - 2'd1;
      end
      default: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
        err_cnt_d = rsp_err_q && err_cnt_q != '1 ? err_cnt_q + 1'b1 : err_cnt_q;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q <= rsp_wr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
